// File: rtl/mem_wb_pipe_reg_pkg.sv
// Shared MEM->WB pipeline definitions: default widths and the stage payload record.
package mem_wb_pipe_reg_pkg;

  localparam int MEM_WB_DATA_W = 32;
  localparam int MEM_WB_DEST_W = 4;

  // Payload at default widths; parametrised instances declare a same-shaped local type.
  typedef struct packed {
    logic                     wb_en;
    logic                     mem_r_en;
    logic [MEM_WB_DATA_W-1:0] alu_result;
    logic [MEM_WB_DATA_W-1:0] mem_read_value;
    logic [MEM_WB_DEST_W-1:0] dest;
  } mem_wb_payload_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer with synchronous flush.
// in_ready is registered; the skid entry absorbs the beat accepted while the sink stalls.
module pipe_skid_buf #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         main_valid, skid_valid, ready_q;
  logic [W-1:0] main_data, skid_data;
  logic         main_valid_n, skid_valid_n;
  logic         load_main_in, load_main_skid, load_skid;
  logic         accept, drain;

  always_comb begin
    accept         = in_valid & ready_q & ~flush;
    drain          = main_valid & out_ready;
    main_valid_n   = main_valid;
    skid_valid_n   = skid_valid;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      main_valid_n = 1'b0;
      skid_valid_n = 1'b0;
    end else begin
      if (drain) begin
        if (skid_valid) begin
          load_main_skid = 1'b1;
          main_valid_n   = 1'b1;
          skid_valid_n   = 1'b0;
        end else if (accept) begin
          load_main_in = 1'b1;
          main_valid_n = 1'b1;
        end else begin
          main_valid_n = 1'b0;
        end
      end
      // Beat not already routed straight into a draining main entry.
      if (accept && !(drain && !skid_valid)) begin
        if (!main_valid) begin
          load_main_in = 1'b1;
          main_valid_n = 1'b1;
        end else begin
          load_skid    = 1'b1;
          skid_valid_n = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      ready_q    <= 1'b1;
      main_data  <= '0;
      skid_data  <= '0;
    end else begin
      main_valid <= main_valid_n;
      skid_valid <= skid_valid_n;
      ready_q    <= ~skid_valid_n;
      if (load_main_skid)
        main_data <= skid_data;
      else if (load_main_in)
        main_data <= in_data;
      if (load_skid)
        skid_data <= in_data;
    end
  end

  assign in_ready  = ready_q;
  assign out_valid = main_valid;
  assign out_data  = main_data;

endmodule

// File: rtl/mem_wb_pipe_reg.sv
// MEM->WB stage register: skid-buffered payload, write-back value mux and
// forwarding tap for the hazard unit. Outputs come only from registers or a 2:1 mux of them.
module mem_wb_pipe_reg
  import mem_wb_pipe_reg_pkg::*;
#(
  parameter int DATA_W = MEM_WB_DATA_W,
  parameter int DEST_W = MEM_WB_DEST_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wb_en,
  input  logic              in_mem_r_en,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_mem_read_value,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_wb_en,
  output logic              out_mem_r_en,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_mem_read_value,
  output logic [DEST_W-1:0] out_dest,
  output logic [DATA_W-1:0] out_wb_value,
  output logic              fwd_valid,
  output logic [DEST_W-1:0] fwd_dest,
  output logic [DATA_W-1:0] fwd_value
);

  typedef struct packed {
    logic              wb_en;
    logic              mem_r_en;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] mem_read_value;
    logic [DEST_W-1:0] dest;
  } payload_t;

  localparam int PL_W = $bits(payload_t);

  payload_t        in_pl, out_pl;
  logic [PL_W-1:0] out_vec;

  assign in_pl.wb_en          = in_wb_en;
  assign in_pl.mem_r_en       = in_mem_r_en;
  assign in_pl.alu_result     = in_alu_result;
  assign in_pl.mem_read_value = in_mem_read_value;
  assign in_pl.dest           = in_dest;

  pipe_skid_buf #(.W(PL_W)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_pl),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_vec)
  );

  assign out_pl             = payload_t'(out_vec);
  assign out_wb_en          = out_pl.wb_en;
  assign out_mem_r_en       = out_pl.mem_r_en;
  assign out_alu_result     = out_pl.alu_result;
  assign out_mem_read_value = out_pl.mem_read_value;
  assign out_dest           = out_pl.dest;
  assign out_wb_value       = out_pl.mem_r_en ? out_pl.mem_read_value : out_pl.alu_result;

  assign fwd_valid = out_valid & out_pl.wb_en;
  assign fwd_dest  = out_pl.dest;
  assign fwd_value = out_wb_value;

endmodule

// File: tb/tb_mem_wb_pipe_reg.sv
// Scoreboard bench for mem_wb_pipe_reg: driver queues expected beats on accept,
// monitor pops and compares on every output transfer.
module tb_mem_wb_pipe_reg;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready;
  logic        in_wb_en, in_mem_r_en;
  logic [31:0] in_alu_result, in_mem_read_value;
  logic [3:0]  in_dest;
  logic        out_valid, out_ready, out_wb_en, out_mem_r_en;
  logic [31:0] out_alu_result, out_mem_read_value, out_wb_value, fwd_value;
  logic [3:0]  out_dest, fwd_dest;
  logic        fwd_valid;

  typedef struct {
    logic        wb_en;
    logic        mem_r_en;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [3:0]  dest;
    logic [31:0] wbv;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start;

  mem_wb_pipe_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_wb_en(in_wb_en), .in_mem_r_en(in_mem_r_en),
    .in_alu_result(in_alu_result), .in_mem_read_value(in_mem_read_value), .in_dest(in_dest),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_wb_en(out_wb_en), .out_mem_r_en(out_mem_r_en),
    .out_alu_result(out_alu_result), .out_mem_read_value(out_mem_read_value), .out_dest(out_dest),
    .out_wb_value(out_wb_value),
    .fwd_valid(fwd_valid), .fwd_dest(fwd_dest), .fwd_value(fwd_value)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every output transfer must match the oldest queued beat.
  initial forever begin
    @(negedge clk);
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("mon_unexpected_beat", {32'd0, out_alu_result}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("mon_alu", out_alu_result, e.alu);
        check("mon_mem", out_mem_read_value, e.mem);
        check("mon_dest", out_dest, e.dest);
        check("mon_wb_en", out_wb_en, e.wb_en);
        check("mon_mem_r_en", out_mem_r_en, e.mem_r_en);
        check("mon_wb_value", out_wb_value, e.wbv);
        check("mon_fwd_valid", fwd_valid, e.wb_en);
        check("mon_fwd_dest", fwd_dest, e.dest);
        check("mon_fwd_value", fwd_value, e.wbv);
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] alu, input logic [31:0] mem, input logic [3:0] dest,
                      input logic wb, input logic mr, input logic [31:0] wbv);
    in_alu_result     = alu;
    in_mem_read_value = mem;
    in_dest           = dest;
    in_wb_en          = wb;
    in_mem_r_en       = mr;
    in_valid          = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        sb.push_back('{wb, mr, alu, mem, dest, wbv});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    n_checks++;
    n_fail++;
    $display("FAIL send_timeout: in_ready got 0 expected 1 for alu %0h", alu);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    for (int k = 0; k < 30; k++) begin
      if (sb.size() == 0) break;
      @(posedge clk);
    end
    #1;
    check("drain_empty", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_wb_en = 1'b0; in_mem_r_en = 1'b0; in_alu_result = '0; in_mem_read_value = '0; in_dest = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_wb_value", out_wb_value, 0);
    check("rst_fwd_valid", fwd_valid, 0);
    check("rst_fwd_dest", fwd_dest, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Streaming, one beat per cycle
    start = cyc;
    for (int i = 0; i < 4; i++)
      send(32'h10 + 32'(i), 32'h0, 4'(i + 1), 1'b1, 1'b0, 32'h10 + 32'(i));
    check("stream_throughput", cyc - start, 4);
    @(negedge clk);
    check("stream_last_valid", out_valid, 1);
    check("stream_last_fwd_dest", fwd_dest, 4);
    @(posedge clk); #1;
    wait_empty();

    // Load mux and one-cycle latency
    send(32'hAAAA, 32'h5555, 4'd5, 1'b1, 1'b1, 32'h5555);
    @(negedge clk);
    check("load_latency_valid", out_valid, 1);
    check("load_wb_value", out_wb_value, 32'h5555);
    @(posedge clk); #1;
    send(32'hAAAA, 32'h5555, 4'd6, 1'b1, 1'b0, 32'hAAAA);
    wait_empty();

    // Back-pressure: 3 cycles of out_ready=0 with in_valid held
    @(posedge clk); #1;
    send(32'h20, 32'h0, 4'd8, 1'b1, 1'b0, 32'h20);
    out_ready = 1'b0;
    send(32'h21, 32'h0, 4'd9, 1'b1, 1'b0, 32'h21);
    in_alu_result = 32'h22; in_dest = 4'd10; in_valid = 1'b1;
    @(negedge clk);
    check("bp_in_ready_low", in_ready, 0);
    check("bp_held_count", sb.size(), 2);
    check("bp_main_alu", out_alu_result, 32'h20);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_in_ready_low2", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready_still_low", in_ready, 0);
    @(posedge clk); #1;
    check("bp_release_in_ready", in_ready, 1);
    check("bp_skid_to_main", out_alu_result, 32'h21);
    send(32'h22, 32'h0, 4'd10, 1'b1, 1'b0, 32'h22);
    send(32'h23, 32'h0, 4'd11, 1'b1, 1'b0, 32'h23);
    wait_empty();

    // Flush with skid full and in_valid=1
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h30, 32'h0, 4'd10, 1'b1, 1'b0, 32'h30);
    send(32'h31, 32'h0, 4'd11, 1'b1, 1'b0, 32'h31);
    in_alu_result = 32'h32; in_dest = 4'd12; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    check("flush_full_out_valid", out_valid, 0);
    check("flush_full_in_ready", in_ready, 1);
    out_ready = 1'b1;

    // Flush with skid empty: the otherwise-acceptable input beat is discarded
    out_ready = 1'b0;
    send(32'h40, 32'h0, 4'd12, 1'b1, 1'b0, 32'h40);
    in_alu_result = 32'h41; in_dest = 4'd13; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0; sb.delete();
    check("flush_main_out_valid", out_valid, 0);
    check("flush_main_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("flush_no_ghost", out_valid, 0);
    @(posedge clk); #1;

    // Bubble
    send(32'h50, 32'h0, 4'd7, 1'b0, 1'b0, 32'h50);
    @(negedge clk);
    check("bubble_out_valid", out_valid, 1);
    check("bubble_fwd_valid", fwd_valid, 0);
    check("bubble_dest", out_dest, 7);
    @(posedge clk); #1;
    wait_empty();

    // Reset mid-stall
    @(posedge clk); #1;
    out_ready = 1'b0;
    send(32'h60, 32'h1, 4'd1, 1'b1, 1'b1, 32'h1);
    send(32'h61, 32'h2, 4'd2, 1'b1, 1'b0, 32'h61);
    in_alu_result = 32'h62; in_valid = 1'b1;
    #3 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_alu", out_alu_result, 0);
    check("mid_rst_wb_value", out_wb_value, 0);
    check("mid_rst_fwd_valid", fwd_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    sb.delete();
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    send(32'h70, 32'h0, 4'd3, 1'b1, 1'b0, 32'h70);
    wait_empty();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
